alu_req_scheduler: RTL

//   Shares one 16-bit ALU among NUM_REQ requesters. Arbitrates round-robin and drives the ALU operands and opcode.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/alu_req_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants, flag bit positions and scheduler state encoding.
package alu_pkg;
  localparam int ALU_W = 16;
  localparam int FUN_W = 4;
  localparam int FLG_W = 5;

  localparam logic [FUN_W-1:0] OP_ADD  = 4'd0;
  localparam logic [FUN_W-1:0] OP_SUB  = 4'd1;
  localparam logic [FUN_W-1:0] OP_MUL  = 4'd2;
  localparam logic [FUN_W-1:0] OP_DIV  = 4'd3;
  localparam logic [FUN_W-1:0] OP_AND  = 4'd4;
  localparam logic [FUN_W-1:0] OP_OR   = 4'd5;
  localparam logic [FUN_W-1:0] OP_XOR  = 4'd6;
  localparam logic [FUN_W-1:0] OP_NOT  = 4'd7;
  localparam logic [FUN_W-1:0] OP_CMP  = 4'd8;
  localparam logic [FUN_W-1:0] OP_INC  = 4'd9;
  localparam logic [FUN_W-1:0] OP_DEC  = 4'd10;
  localparam logic [FUN_W-1:0] OP_NEG  = 4'd11;
  localparam logic [FUN_W-1:0] OP_PASS = 4'd12;
  localparam logic [FUN_W-1:0] OP_SHR  = 4'd13;
  localparam logic [FUN_W-1:0] OP_SHL  = 4'd14;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ARITH = 1;
  localparam int FLG_LOGIC = 2;
  localparam int FLG_CMP   = 3;
  localparam int FLG_SHIFT = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from i_ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    logic [IW-1:0] w_j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin sharing of one 16-bit ALU among NUM_REQ requesters, one op in flight.
// Optional ALU_SCHED_DIV0_EN: DIV by zero is answered with RSP_ERR instead of being issued.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ALU_LAT = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [ALU_W*NUM_REQ-1:0] i_req_a,
  input  logic [ALU_W*NUM_REQ-1:0] i_req_b,
  input  logic [FUN_W*NUM_REQ-1:0] i_req_fun,
  output logic [ALU_W-1:0]         o_alu_a,
  output logic [ALU_W-1:0]         o_alu_b,
  output logic [FUN_W-1:0]         o_alu_fun,
  input  logic [ALU_W-1:0]         i_alu_res,
  input  logic [FLG_W-1:0]         i_alu_flags,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [IW-1:0]            o_rsp_id,
  output logic [ALU_W-1:0]         o_rsp_data,
  output logic [FLG_W-1:0]         o_rsp_flags,
  output logic                     o_rsp_err
);
  sched_state_t       r_state;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [ALU_W-1:0]   r_alu_a, r_alu_b, r_rsp_data;
  logic [FUN_W-1:0]   r_alu_fun;
  logic [FLG_W-1:0]   r_rsp_flags;
  logic [IW-1:0]      r_rsp_id;
  logic               r_rsp_valid;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx, w_ptr_nxt;
  logic               w_any, w_div0;
  logic [ALU_W-1:0]   w_sel_a, w_sel_b;
  logic [FUN_W-1:0]   w_sel_fun;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_sel_a   = i_req_a[ALU_W*w_idx +: ALU_W];
  assign w_sel_b   = i_req_b[ALU_W*w_idx +: ALU_W];
  assign w_sel_fun = i_req_fun[FUN_W*w_idx +: FUN_W];
  assign w_ptr_nxt = (w_idx == IW'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

  // Ready is combinational from the arbiter; masked by reset so every output reads 0 then.
  assign o_req_ready = (r_state == IDLE && i_rst_n) ? w_gnt : '0;

`ifdef ALU_SCHED_DIV0_EN
  logic r_err;
  assign w_div0    = (w_sel_fun == OP_DIV) && (w_sel_b == '0);
  assign o_rsp_err = r_err;

  // Error tag is latched at grant and rides along until the next grant.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)                     r_err <= 1'b0;
    else if (r_state == IDLE && w_any) r_err <= w_div0;
`else
  assign w_div0    = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_ptr    <= w_ptr_nxt;
          r_rsp_id <= w_idx;
          if (w_div0) begin
            // Rejected op: ALU operands left untouched, answer immediately.
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_fun <= w_sel_fun;
            r_cnt     <= CW'(ALU_LAT-1);
            r_state   <= EXEC;
          end
        end
        EXEC: if (r_cnt == '0) begin
          r_rsp_data  <= i_alu_res;
          r_rsp_flags <= i_alu_flags;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_fun   = r_alu_fun;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_flags = r_rsp_flags;
endmodule
